// File: rtl/sata_link_sup_pkg.sv
// Shared types for the SATA link supervisor: FSM state encoding and SStatus.DET codes.
package sata_link_sup_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HOLD,
      ST_RELEASE,
      ST_WAIT,
      ST_UP,
      ST_OFFLINE,
      ST_FAILED
   } state_e;

   localparam logic [3:0] DET_NONE = 4'd0;
   localparam logic [3:0] DET_TRY  = 4'd1;
   localparam logic [3:0] DET_UP   = 4'd3;
   localparam logic [3:0] DET_OFF  = 4'd4;

   function automatic logic [3:0] det_of(input state_e s);
      case (s)
         ST_IDLE:    return DET_NONE;
         ST_UP:      return DET_UP;
         ST_OFFLINE: return DET_OFF;
         default:    return DET_TRY;
      endcase
   endfunction

endpackage

// File: rtl/link_sup_timer.sv
// Loadable saturating up-counter with clear and compare-equal, shared by the
// HOLD, WAIT and link-loss filter phases of the supervisor.
module link_sup_timer #(
   parameter int TIMER_BITS = 20
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr_i,
   input  logic                  load_i,
   input  logic [TIMER_BITS-1:0] load_val_i,
   input  logic                  inc_i,
   input  logic [TIMER_BITS-1:0] cmp_i,
   output logic                  eq_o
);

   logic [TIMER_BITS-1:0] count_q;

   // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (clr_i) begin
         count_q <= '0;
      end else if (load_i) begin
         count_q <= load_val_i;
      end else if (inc_i && (count_q != '1)) begin
         count_q <= count_q + TIMER_BITS'(1);
      end
   end

   assign eq_o = (count_q == cmp_i);

endmodule

// File: rtl/sata_link_supervisor.sv
// SATA link bring-up/recovery supervisor: COMRESET sequencing, link timeout with
// bounded retries, filtered link-loss detection and DET/event reporting.
module sata_link_supervisor
   import sata_link_sup_pkg::*;
#(
   parameter int OFFLINE_CYCLES = 1024,
   parameter int TIMER_BITS     = 20,
   parameter int LINK_TIMEOUT   = 'hFFFFF,
   parameter int MAX_RETRIES    = 3,
   parameter int DOWN_FILTER    = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       gtx_ready,
   input  logic       phy_ready,
   input  logic       cmd_comreset,
   input  logic       cmd_offline,
   output logic       set_offline,
   output logic       comreset_send,
   output logic [3:0] det,
   output logic [3:0] retry_cnt,
   output logic       evt_link_up,
   output logic       evt_link_down,
   output logic       evt_fail
);

   state_e                state_q, state_d;
   logic                  set_offline_q, set_offline_d;
   logic                  comreset_q;
   logic [3:0]            det_q;
   logic [3:0]            retry_q, retry_d;
   logic                  evt_up_q, evt_up_d;
   logic                  evt_down_q, evt_down_d;
   logic                  evt_fail_q, evt_fail_d;
   logic                  tmr_clr, tmr_inc, tmr_eq;
   logic [TIMER_BITS-1:0] tmr_cmp;

   link_sup_timer #(.TIMER_BITS(TIMER_BITS)) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_i      (tmr_clr),
      .load_i     (1'b0),
      .load_val_i ('0),
      .inc_i      (tmr_inc),
      .cmp_i      (tmr_cmp),
      .eq_o       (tmr_eq)
   );

   // Compare target kept apart from the FSM so tmr_eq never feeds back into its own block.
   always_comb begin
      tmr_cmp = TIMER_BITS'(DOWN_FILTER);
      case (state_q)
         ST_HOLD: tmr_cmp = TIMER_BITS'(OFFLINE_CYCLES);
         ST_WAIT: tmr_cmp = TIMER_BITS'(LINK_TIMEOUT);
         default: ;
      endcase
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d       = state_q;
      set_offline_d = 1'b0;
      evt_up_d      = 1'b0;
      evt_down_d    = 1'b0;
      evt_fail_d    = 1'b0;
      retry_d       = retry_q;
      tmr_clr       = 1'b0;
      tmr_inc       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (gtx_ready) begin
               state_d       = ST_HOLD;
               set_offline_d = 1'b1;
               tmr_clr       = 1'b1;
            end
         end
         ST_HOLD: begin
            if (tmr_eq) begin
               state_d = ST_RELEASE;
               tmr_clr = 1'b1;
            end else begin
               tmr_inc = 1'b1;
            end
         end
         ST_RELEASE: begin
            state_d = ST_WAIT;
            tmr_clr = 1'b1;
         end
         ST_WAIT: begin
            if (phy_ready) begin
               state_d  = ST_UP;
               evt_up_d = 1'b1;
               tmr_clr  = 1'b1;
            end else if (tmr_eq) begin
               tmr_clr = 1'b1;
               if (retry_q < 4'(MAX_RETRIES)) begin
                  state_d       = ST_HOLD;
                  retry_d       = retry_q + 4'd1;
                  set_offline_d = 1'b1;
               end else begin
                  state_d    = ST_FAILED;
                  evt_fail_d = 1'b1;
               end
            end else begin
               tmr_inc = 1'b1;
            end
         end
         ST_UP: begin
            // Timer holds the count of consecutive low samples already seen.
            if (tmr_eq) begin
               state_d       = ST_HOLD;
               evt_down_d    = 1'b1;
               set_offline_d = 1'b1;
               retry_d       = 4'd0;
               tmr_clr       = 1'b1;
            end else if (phy_ready) begin
               tmr_clr = 1'b1;
            end else begin
               tmr_inc = 1'b1;
            end
         end
         default: ;
      endcase

      if (cmd_offline) begin
         state_d       = ST_OFFLINE;
         set_offline_d = 1'b1;
         evt_up_d      = 1'b0;
         evt_down_d    = 1'b0;
         evt_fail_d    = 1'b0;
         tmr_clr       = 1'b1;
      end else if (!gtx_ready && (state_q != ST_OFFLINE)) begin
         state_d       = ST_IDLE;
         set_offline_d = 1'b0;
         evt_up_d      = 1'b0;
         evt_down_d    = 1'b0;
         evt_fail_d    = 1'b0;
         retry_d       = 4'd0;
         tmr_clr       = 1'b1;
      end else if (cmd_comreset) begin
         state_d       = ST_HOLD;
         set_offline_d = 1'b1;
         evt_up_d      = 1'b0;
         evt_down_d    = 1'b0;
         evt_fail_d    = 1'b0;
         retry_d       = 4'd0;
         tmr_clr       = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         set_offline_q <= 1'b0;
         comreset_q    <= 1'b0;
         det_q         <= DET_NONE;
         retry_q       <= 4'd0;
         evt_up_q      <= 1'b0;
         evt_down_q    <= 1'b0;
         evt_fail_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         set_offline_q <= set_offline_d;
         comreset_q    <= (state_d == ST_RELEASE);
         det_q         <= det_of(state_d);
         retry_q       <= retry_d;
         evt_up_q      <= evt_up_d;
         evt_down_q    <= evt_down_d;
         evt_fail_q    <= evt_fail_d;
      end
   end

   assign set_offline   = set_offline_q;
   assign comreset_send = comreset_q;
   assign det           = det_q;
   assign retry_cnt     = retry_q;
   assign evt_link_up   = evt_up_q;
   assign evt_link_down = evt_down_q;
   assign evt_fail      = evt_fail_q;

endmodule

// File: tb/tb_sata_link_supervisor.sv
// Directed-plus-random bench for sata_link_supervisor; expected event cycles are
// derived arithmetically from the link bring-up timing rules.
module tb_sata_link_supervisor;

   localparam int OC = 1024;
   localparam int TB = 20;
   localparam int LT = 100;
   localparam int MR = 3;
   localparam int DF = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       gtx_ready, phy_ready, cmd_comreset, cmd_offline;
   logic       set_offline, comreset_send, evt_link_up, evt_link_down, evt_fail;
   logic [3:0] det, retry_cnt;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int n_so = 0, n_cr = 0, n_up = 0, n_dn = 0, n_fl = 0, n_clash = 0, n_crbad = 0;
   int last_so = -1, last_cr = -1, last_up = -1, last_dn = -1, last_fl = -1;

   sata_link_supervisor #(
      .OFFLINE_CYCLES (OC),
      .TIMER_BITS     (TB),
      .LINK_TIMEOUT   (LT),
      .MAX_RETRIES    (MR),
      .DOWN_FILTER    (DF)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .gtx_ready     (gtx_ready),
      .phy_ready     (phy_ready),
      .cmd_comreset  (cmd_comreset),
      .cmd_offline   (cmd_offline),
      .set_offline   (set_offline),
      .comreset_send (comreset_send),
      .det           (det),
      .retry_cnt     (retry_cnt),
      .evt_link_up   (evt_link_up),
      .evt_link_down (evt_link_down),
      .evt_fail      (evt_fail)
   );

   always #5 clk = ~clk;

   // Event log: every output pulse is timestamped with the cycle it is visible in.
   always @(posedge clk) begin
      cyc = cyc + 1;
      #1;
      if (set_offline)   begin n_so++; last_so = cyc; end
      if (comreset_send) begin n_cr++; last_cr = cyc; end
      if (evt_link_up)   begin n_up++; last_up = cyc; end
      if (evt_link_down) begin n_dn++; last_dn = cyc; end
      if (evt_fail)      begin n_fl++; last_fl = cyc; end
      if (set_offline && comreset_send) n_clash++;
      if (comreset_send && (det != 4'd1)) n_crbad++;
   end

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic goto(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic pulse_cmd(input logic off, input logic cr);
      cmd_offline  = off;
      cmd_comreset = cr;
      tick(1);
      cmd_offline  = 1'b0;
      cmd_comreset = 1'b0;
   endtask

   initial begin
      int so_e, cr_e, nxt, d, k, len, so_cnt, cr_cnt;

      rst_n = 1'b0; gtx_ready = 1'b0; phy_ready = 1'b0;
      cmd_comreset = 1'b0; cmd_offline = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(2);
      check("reset_det", det, 0);
      check("reset_retry", retry_cnt, 0);
      check("reset_pulses", n_so + n_cr + n_up + n_dn + n_fl, 0);

      // Bring-up with random phy_ready delay inside the timeout window
      k = cyc;
      gtx_ready = 1'b1;
      tick(1);
      check("bringup_so_cycle", last_so, k + 1);
      check("bringup_hold_det", det, 1);
      cr_e = k + 1 + OC + 1;
      goto(cr_e);
      check("bringup_cr_cycle", last_cr, cr_e);
      d = $urandom_range(1, LT - 1);
      tick(d);
      phy_ready = 1'b1;
      tick(1);
      check("bringup_up_cycle", last_up, cr_e + d + 1);
      check("bringup_det", det, 3);
      check("bringup_retry", retry_cnt, 0);

      // Dropouts shorter than the filter, including the longest legal one
      for (int i = 0; i < 4; i++) begin
         len = (i == 0) ? DF - 1 : $urandom_range(1, DF - 1);
         phy_ready = 1'b0;
         tick(len);
         phy_ready = 1'b1;
         tick($urandom_range(2, 20));
      end
      check("short_drop_no_evt", n_dn, 0);
      check("short_drop_det", det, 3);

      // Full-length dropout declares link loss and restarts bring-up
      k = cyc;
      phy_ready = 1'b0;
      tick(DF + 1);
      check("down_cycle", last_dn, k + DF + 1);
      check("down_so_cycle", last_so, k + DF + 1);
      check("down_det", det, 1);

      // phy_ready stays low: every attempt times out until retries run out
      so_e = k + DF + 1;
      for (int i = 0; i <= MR; i++) begin
         cr_e = so_e + OC + 1;
         goto(cr_e);
         check("retry_cr_cycle", last_cr, cr_e);
         nxt = cr_e + LT + 2;
         goto(nxt);
         if (i < MR) begin
            check("retry_so_cycle", last_so, nxt);
            check("retry_cnt_step", retry_cnt, i + 1);
            so_e = nxt;
         end else begin
            check("fail_cycle", last_fl, nxt);
            check("fail_det", det, 1);
            check("fail_retry", retry_cnt, MR);
         end
      end
      check("retry_cr_total", n_cr, 2 + MR);
      cr_cnt = n_cr;
      tick(300);
      check("failed_holds", n_cr, cr_cnt);
      check("fail_pulse_once", n_fl, 1);

      // cmd_comreset restarts; phy_ready arrives exactly on the timeout cycle
      k = cyc;
      pulse_cmd(1'b0, 1'b1);
      check("restart_so_cycle", last_so, k + 1);
      check("restart_retry", retry_cnt, 0);
      so_cnt = n_so;
      cr_e = k + 1 + OC + 1;
      goto(cr_e);
      tick(LT + 1);
      phy_ready = 1'b1;
      tick(1);
      check("tie_up_cycle", last_up, cr_e + LT + 2);
      check("tie_no_retry", n_so, so_cnt);
      check("tie_det", det, 3);

      // Offline from UP; random phy activity must not wake it
      k = cyc;
      pulse_cmd(1'b1, 1'b0);
      check("offline_so_cycle", last_so, k + 1);
      check("offline_det", det, 4);
      so_cnt = n_so;
      cr_cnt = n_cr;
      for (int i = 0; i < 10; i++) begin
         phy_ready = 1'($urandom_range(0, 1));
         tick(1000);
      end
      check("offline_no_cr", n_cr, cr_cnt);
      check("offline_no_so", n_so, so_cnt);
      check("offline_hold_det", det, 4);
      pulse_cmd(1'b1, 1'b1);
      check("both_cmds_det", det, 4);
      check("both_cmds_no_cr", n_cr, cr_cnt);

      // Leave offline, consume one retry, then lose gtx_ready during WAIT
      phy_ready = 1'b0;
      k = cyc;
      pulse_cmd(1'b0, 1'b1);
      check("reopen_det", det, 1);
      cr_e = k + 1 + OC + 1;
      nxt = cr_e + LT + 2;
      goto(nxt);
      check("reopen_retry", retry_cnt, 1);
      so_cnt = n_so;
      goto(nxt + OC + 1 + $urandom_range(2, LT - 1));
      gtx_ready = 1'b0;
      tick(1);
      check("gtx_drop_det", det, 0);
      check("gtx_drop_retry", retry_cnt, 0);
      check("gtx_drop_no_so", n_so, so_cnt);
      cr_cnt = n_cr;
      tick(200);
      check("gtx_idle_no_cr", n_cr, cr_cnt);

      // Asynchronous reset lands on a set_offline pulse in HOLD with retry_cnt=1
      k = cyc;
      gtx_ready = 1'b1;
      tick(1);
      cr_e = k + 1 + OC + 1;
      nxt = cr_e + LT + 2;
      goto(nxt);
      check("pre_reset_so", int'(set_offline), 1);
      check("pre_reset_retry", retry_cnt, 1);
      rst_n = 1'b0;
      #1;
      check("async_reset_outputs",
            int'({set_offline, comreset_send, det, retry_cnt, evt_link_up, evt_link_down, evt_fail}), 0);
      gtx_ready = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(3);
      check("post_reset_det", det, 0);

      check("no_so_cr_clash", n_clash, 0);
      check("cr_only_when_trying", n_crbad, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sata_link_supervisor.md
# sata_link_supervisor

Sequences link bring-up and recovery for the SATA PHY OOB controller. It issues the `set_offline` / `comreset_send` pulse pair that forces a fresh OOB sequence, times out link attempts, and retries a bounded number of times. It debounces loss of `phy_ready` and reports an SStatus.DET-style link state plus event pulses to the AHCI register layer. It sits between the AHCI control registers and the OOB control block, in the `clk` (usrclk2) domain.

## Interface
Parameters:
- OFFLINE_CYCLES, 1024: electrical-idle hold time before COMRESET release (≥2).
- TIMER_BITS, 20: width of the link-wait timer.
- LINK_TIMEOUT, 20'hFFFFF: cycles allowed from release to `phy_ready` (< 2^TIMER_BITS).
- MAX_RETRIES, 3: automatic re-attempts after the first timeout (1..15).
- DOWN_FILTER, 16: consecutive cycles `phy_ready`=0 required to declare link loss (≥1).

Ports:
- clk  in  1  SATA clock (usrclk2).
- rst_n  in  1  asynchronous, active-low reset.
- gtx_ready  in  1  transceiver resets complete.
- phy_ready  in  1  link established, from OOB control.
- cmd_comreset  in  1  one-cycle request: restart link, clear retry count.
- cmd_offline  in  1  one-cycle request: hold PHY offline.
- set_offline  out  1  one-cycle pulse to OOB control (force electrical idle).
- comreset_send  out  1  one-cycle pulse to OOB control (release, start OOB).
- det  out  4  0 = no device/idle, 1 = attempting, 3 = link up, 4 = offline.
- retry_cnt  out  4  attempts consumed in the current bring-up.
- evt_link_up  out  1  one-cycle pulse on entering UP.
- evt_link_down  out  1  one-cycle pulse on filtered loss of link.
- evt_fail  out  1  one-cycle pulse on entering FAILED.

## Operation
States: IDLE, HOLD, RELEASE, WAIT, UP, OFFLINE, FAILED.
- IDLE: det=0. When `gtx_ready`=1, go to HOLD and pulse `set_offline`.
- HOLD: det=1. Count OFFLINE_CYCLES, then go to RELEASE.
- RELEASE: pulse `comreset_send` for one cycle, clear the timer, go to WAIT.
- WAIT: det=1. If `phy_ready`=1, go to UP and pulse `evt_link_up`. If the timer reaches LINK_TIMEOUT:
  - retry_cnt < MAX_RETRIES: increment retry_cnt, pulse `set_offline`, go to HOLD.
  - otherwise: go to FAILED and pulse `evt_fail`.
- UP: det=3. If `phy_ready`=0 for DOWN_FILTER consecutive cycles, pulse `evt_link_down`, clear retry_cnt, pulse `set_offline`, go to HOLD. A shorter dropout resets the filter counter.
- OFFLINE: det=4. `set_offline` was pulsed on entry. The state holds until `cmd_comreset`.
- FAILED: det=1. The state holds until `cmd_comreset`.

Commands apply in every state:
- `cmd_offline`: go to OFFLINE and pulse `set_offline`.
- `cmd_comreset`: clear retry_cnt, pulse `set_offline`, go to HOLD.
- Both asserted in the same cycle: `cmd_offline` wins.

Rules:
- `gtx_ready` falling in any state other than OFFLINE returns the block to IDLE and clears retry_cnt; no pulse is issued.
- `set_offline` and `comreset_send` are never asserted in the same cycle.
- `comreset_send` is asserted only in RELEASE.

## Timing
- Reset values: state IDLE, all outputs 0, counters 0.
- Outputs are registered. A pulse appears in the cycle after the causing input or state edge.
- HOLD→RELEASE→WAIT: `set_offline` to `comreset_send` spacing is exactly OFFLINE_CYCLES+1 cycles.
- Timeout is declared on the cycle the WAIT counter equals LINK_TIMEOUT. If `phy_ready`=1 in that same cycle, the link-up path wins.
- `evt_link_down` fires DOWN_FILTER+1 cycles after `phy_ready` falls.
- The timer saturates and never wraps.
- Reset mid-operation returns to IDLE immediately (asynchronous). Pulses are truncated cleanly.

## Structure
- Shared package `sata_link_sup_pkg` holds the state enum and the DET code constants (DET_NONE=0, DET_TRY=1, DET_UP=3, DET_OFF=4).
- One sub-module, `link_sup_timer`: a TIMER_BITS-wide loadable, saturating counter with clear and compare-equal. It is reused for the HOLD count, the WAIT count and the DOWN_FILTER count.

## Test plan
- Bring-up: release `rst_n`, `gtx_ready`=1, `phy_ready` rises 500 cycles after `comreset_send` → `set_offline` pulse, then `comreset_send` 1025 cycles later; then `evt_link_up`, det=3, retry_cnt=0.
- Retry exhaustion: `phy_ready` held 0 with LINK_TIMEOUT=100 → 4 `comreset_send` pulses, retry_cnt=3, `evt_fail`, det=1; a later `cmd_comreset` restarts with retry_cnt=0.
- Dropout filter: in UP, drop `phy_ready` for 15 cycles → no event, det stays 3. Drop for 16 cycles → `evt_link_down`, then a new HOLD sequence.
- Offline: in UP, `cmd_offline` → one `set_offline` pulse, det=4, no `comreset_send` for 10k cycles. `cmd_comreset` and `cmd_offline` in the same cycle → det=4.
- Timeout tie: `phy_ready` rises exactly at LINK_TIMEOUT → UP with no retry; `gtx_ready` dropping in WAIT → IDLE, det=0.
- Async reset asserted during HOLD → all outputs 0 in the same cycle.
